cond_logic: RTL and testbench

Conditional-execution stage sitting directly downstream of the instruction decoder in the single-cycle ARMv4 datapath. It holds the architectural NZCV flag register and evaluates the 4-bit condition field Instr[31:28] against the current flags. It gates the decoder's PCS/RegW/MemW requests into the final PCSrc/RegWrite/MemWrite strobes. It also updates the flags from the ALU under control of the decoder's FlagW.

---
 rtl/cond_logic.sv | 69 ++++++
 tb/tb_cond_logic.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the instruction
// condition field against them and gates the decoder's write requests.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_q, flags_d;
  logic       n_f, z_f, c_f, v_f;
  logic       base_pass;
  logic       go;
  logic       wr_nz, wr_cv;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Codes pair up as (test, !test) on Cond[0]; 111x is always-pass.
  always_comb begin
    base_pass = 1'b0;
    unique case (Cond[3:1])
      3'b000:  base_pass = z_f;
      3'b001:  base_pass = c_f;
      3'b010:  base_pass = n_f;
      3'b011:  base_pass = v_f;
      3'b100:  base_pass = c_f & ~z_f;
      3'b101:  base_pass = ~(n_f ^ v_f);
      3'b110:  base_pass = ~z_f & ~(n_f ^ v_f);
      default: base_pass = 1'b1;
    endcase
  end

  assign CondEx = (Cond[3:1] == 3'b111) ? 1'b1 : (base_pass ^ Cond[0]);

  assign go       = CondEx & en & ~reset;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & ~NoWrite & go;
  assign MemWrite = MemW & go;

  // Write enables resolve to 0 whenever en or CondEx is 0, so X on
  // FlagW/ALUFlags cannot leak into the held flags.
  assign wr_nz = en & CondEx & FlagW[1];
  assign wr_cv = en & CondEx & FlagW[0];

  always_comb begin
    flags_d = flags_q;
    if (wr_nz) flags_d[3:2] = ALUFlags[3:2];
    if (wr_cv) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign Flags = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, CMP/branch sequence, partial flag
// writes, failed conditions, full condition sweep, stall and mid-op reset.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;

  cond_logic dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference condition table written straight from the ARM mapping.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the flag register through an AL flag-setting instruction.
  task automatic set_flags(input logic [3:0] f);
    en = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    // Reset
    reset = 1; en = 1; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1; RegW = 1; MemW = 1; NoWrite = 0;
    #1;
    check("rst_strobes_pre", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    check("rst_flags_c1", Flags, 4'b0000);
    check("rst_strobes_c1", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    check("rst_flags_c2", Flags, 4'b0000);
    check("rst_strobes_c2", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    reset = 0; PCS = 0; RegW = 0; MemW = 0;
    Cond = 4'b0000; #1;
    check("rst_eq_condex", {3'b0, CondEx}, 4'b0000);
    Cond = 4'b0001; #1;
    check("rst_ne_condex", {3'b0, CondEx}, 4'b0001);

    // CMP with equal operands, then BEQ / BNE
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; RegW = 1; NoWrite = 1; ALUFlags = 4'b0110;
    #1;
    check("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("cmp_condex", {3'b0, CondEx}, 4'b0001);
    tick();
    check("cmp_flags", Flags, 4'b0110);
    FlagW = 2'b00; RegW = 0; NoWrite = 0; PCS = 1;
    Cond = 4'b0000; #1;
    check("beq_pcsrc", {3'b0, PCSrc}, 4'b0001);
    Cond = 4'b0001; #1;
    check("bne_pcsrc", {3'b0, PCSrc}, 4'b0000);
    PCS = 0;

    // Partial updates
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1001;
    tick();
    check("partial_nz", Flags, 4'b1010);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    check("partial_cv", Flags, 4'b1011);

    // Failed condition must not write flags or memory
    set_flags(4'b0100);
    check("fail_setup", Flags, 4'b0100);
    Cond = 4'b0001; FlagW = 2'b11; MemW = 1; ALUFlags = 4'b1111;
    #1;
    check("fail_memwrite", {3'b0, MemWrite}, 4'b0000);
    check("fail_condex", {3'b0, CondEx}, 4'b0000);
    tick();
    check("fail_flags", Flags, 4'b0100);
    MemW = 0;

    // Failed condition with X on ALUFlags/FlagW
    FlagW = 2'bxx; ALUFlags = 4'bxxxx;
    tick();
    check("fail_x_flags", Flags, 4'b0100);

    // Full sweep of flags x condition codes
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        check($sformatf("sweep_f%0h_c%0h", f, c), {3'b0, CondEx},
              {3'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Spot checks
    set_flags(4'b1000); Cond = 4'b1010; #1;
    check("spot_ge", {3'b0, CondEx}, 4'b0000);
    set_flags(4'b1001); Cond = 4'b1100; #1;
    check("spot_gt", {3'b0, CondEx}, 4'b0001);
    set_flags(4'b0010); Cond = 4'b1000; #1;
    check("spot_hi", {3'b0, CondEx}, 4'b0001);

    // Stall
    set_flags(4'b0101);
    en = 0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1;
    #1;
    check("stall_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("stall_condex", {3'b0, CondEx}, 4'b0001);
    tick();
    check("stall_flags", Flags, 4'b0101);
    FlagW = 2'bxx; ALUFlags = 4'bxxxx;
    tick();
    check("stall_x_flags", Flags, 4'b0101);

    // Reset mid-operation discards the concurrent flag write
    reset = 1; en = 1; FlagW = 2'b11; ALUFlags = 4'b1111; PCS = 1; MemW = 1;
    #1;
    check("midrst_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    check("midrst_flags", Flags, 4'b0000);
    reset = 0; PCS = 0; RegW = 0; MemW = 0; ALUFlags = 4'b0011;
    tick();
    check("resume_flags", Flags, 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
